// File: rtl/nrs_cinit_ctrl_pkg.sv
// Shared widths, limits and FSM encoding for the NRS c_init sequencer.
package nrs_cinit_ctrl_pkg;

    localparam int unsigned NS_W    = 5;
    localparam int unsigned L_W     = 3;
    localparam int unsigned NID_W   = 9;
    localparam int unsigned ACC_W   = 18;
    localparam int unsigned CINIT_W = 31;

    localparam int unsigned A_W       = 8;
    localparam int unsigned B_W       = NID_W + 1;
    localparam int unsigned MUL_STEPS = 8;

    localparam int unsigned NS_MAX    = 19;
    localparam int unsigned L_MAX     = 6;
    localparam logic        NORMAL_CP = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StA0,
        StA1,
        StA2,
        StMul,
        StDone
    } state_e;

endpackage

// File: rtl/nrs_cinit_ctrl_add.sv
// Shared registered adder: combinational sum plus an enabled accumulator register.
module nrs_cinit_ctrl_add #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    assign sum_o = a_i + b_i;
    assign q_o   = q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= sum_o;
        end
    end

endmodule

// File: rtl/nrs_cinit_ctrl.sv
// NRS c_init sequencer: 2^10*A*B + B with one time-multiplexed adder (shift-add multiply).
// Optional NRS_CINIT_EARLY_EXIT_EN stops the multiply once the remaining bits of A are zero.
module nrs_cinit_ctrl
    import nrs_cinit_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [NS_W-1:0]    ns_i,
    input  logic [L_W-1:0]     l_i,
    input  logic [NID_W-1:0]   n_id_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CINIT_W-1:0] cinit_o
);

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [NS_W-1:0]      ns_q;
    logic [L_W-1:0]       l_q;
    logic [B_W-1:0]       b_q;
    logic [A_W-1:0]       a_q;
    logic [CINIT_W-1:0]   cinit_q;
    logic                 done_q, err_q;

    logic                 add_en;
    logic [ACC_W-1:0]     add_a, add_b, add_sum, acc_q;
    logic                 in_range, start_ok, start_bad, mul_last;
    logic                 unused_sum_hi;

    assign in_range  = (ns_i <= NS_W'(NS_MAX)) && (l_i <= L_W'(L_MAX));
    assign start_ok  = start_i && (state_q == StIdle) && in_range;
    assign start_bad = start_i && (state_q == StIdle) && !in_range;

`ifdef NRS_CINIT_EARLY_EXIT_EN
    assign mul_last = (cnt_q == 3'(MUL_STEPS - 1)) || ((a_q >> (4'(cnt_q) + 4'd1)) == '0);
`else
    assign mul_last = (cnt_q == 3'(MUL_STEPS - 1));
`endif

    nrs_cinit_ctrl_add #(
        .WIDTH (ACC_W)
    ) u_add (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (add_en),
        .a_i    (add_a),
        .b_i    (add_b),
        .sum_o  (add_sum),
        .q_o    (acc_q)
    );

    assign unused_sum_hi = ^add_sum[ACC_W-1:A_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StA0;
            StA0:    state_d = StA1;
            StA1:    state_d = StA2;
            StA2:    state_d = StMul;
            StMul:   if (mul_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Adder operand selection; step 0 of the multiply muxes the accumulator to 0 instead of clearing it.
    always_comb begin
        add_en = 1'b0;
        add_a  = '0;
        add_b  = '0;
        cnt_d  = cnt_q;
        unique case (state_q)
            StA0: begin
                add_en = 1'b1;
                add_a  = ACC_W'(ns_q) << 2;
                add_b  = ACC_W'(ns_q) << 1;
            end
            StA1: begin
                add_en = 1'b1;
                add_a  = acc_q;
                add_b  = ACC_W'(ns_q);
            end
            StA2: begin
                add_en = 1'b1;
                add_a  = acc_q;
                add_b  = ACC_W'({1'b1, l_q});
                cnt_d  = '0;
            end
            StMul: begin
                add_en = 1'b1;
                add_a  = (cnt_q == '0) ? '0 : acc_q;
                add_b  = a_q[cnt_q] ? (ACC_W'(b_q) << cnt_q) : '0;
                cnt_d  = cnt_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            ns_q    <= '0;
            l_q     <= '0;
            b_q     <= '0;
            a_q     <= '0;
            cinit_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (state_q == StDone);
            err_q  <= start_bad;
            if (start_ok) begin
                ns_q <= ns_i;
                l_q  <= l_i;
                b_q  <= {n_id_i, NORMAL_CP};
            end
            if (state_q == StA2) begin
                a_q <= add_sum[A_W-1:0];
            end
            // B is odd and below 2^10, so OR-ing it under the shifted product never carries.
            if (state_q == StDone) begin
                cinit_q <= CINIT_W'({acc_q, {B_W{1'b0}}} | (ACC_W + B_W)'(b_q));
            end
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign cinit_o = cinit_q;

endmodule
